// File: rtl/branch_target_predictor_if.sv
// Fetch/execute bus of the branch target predictor.
//   fetch_pc        : PC looked up this cycle (driven by fetch)
//   predict_taken   : BTB hit whose counter predicts taken
//   predict_next_pc : predicted next fetch PC
//   update_en       : execute resolved a control-flow instruction this cycle
//   update_pc       : PC of the resolved instruction
//   update_target   : resolved target address
//   update_taken    : resolved outcome, 1 = taken/jump
//   flush           : invalidate every entry at the next edge
// master = pipeline side, slave = predictor.
interface branch_target_predictor_if;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_next_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        flush;

    modport master (
        output fetch_pc,
        input  predict_taken,
        input  predict_next_pc,
        output update_en,
        output update_pc,
        output update_target,
        output update_taken,
        output flush
    );

    modport slave (
        input  fetch_pc,
        output predict_taken,
        output predict_next_pc,
        input  update_en,
        input  update_pc,
        input  update_target,
        input  update_taken,
        input  flush
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of branch_target_predictor_if (fetch lookup, execute update, flush)
// Lookup is combinational from registered state; updates land on the next rising edge, so a
// same-cycle lookup of the entry being updated sees the old contents.
module branch_target_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = 30 - IDX_W
) (
    input logic                      clk,
    input logic                      rst_n,
    branch_target_predictor_if.slave bus
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [IDX_W-1:0] fetch_idx, upd_idx;
    logic [TAG_W-1:0] fetch_tag, upd_tag;
    logic             fetch_hit, upd_hit;

    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign fetch_tag = bus.fetch_pc[31:IDX_W+2];
    assign upd_idx   = bus.update_pc[IDX_W+1:2];
    assign upd_tag   = bus.update_pc[31:IDX_W+2];

    // valid gates the tag compare so uninitialised tags/targets never reach the outputs.
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        bus.predict_taken   = fetch_hit && ctr_q[fetch_idx][1];
        bus.predict_next_pc = bus.predict_taken ? target_q[fetch_idx] : bus.fetch_pc + 32'd4;
    end

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bus.flush) begin
            // Counters and targets survive a flush; only the valid bits drop.
            valid_d = '0;
        end else if (bus.update_en) begin
            if (upd_hit) begin
                if (bus.update_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                    end
                    target_d[upd_idx] = bus.update_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end else if (bus.update_taken) begin
                // Allocate (or evict an alias) as weakly taken.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bus.update_target;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
    localparam int unsigned ENTRIES = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_target_predictor_if bus ();

    branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: plain arrays with integer counters clamped to 0..3.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];

    logic        obs_taken;
    logic [31:0] obs_pc;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] n);
        int unsigned i = idx_of(pc);
        bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        t = hit && (m_ctr[i] >= 2);
        n = t ? m_target[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic en, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic fl);
        int unsigned i = idx_of(pc);
        bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (fl) begin
            for (int k = 0; k < int'(ENTRIES); k++) m_valid[k] = 0;
        end else if (en) begin
            if (hit && tk) begin
                m_ctr[i]    = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = tgt;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end else if (tk) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(pc);
                m_target[i] = tgt;
                m_ctr[i]    = 2;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare lookup against the model, then advance the model
    // to the state the DUT will hold after the coming rising edge.
    task automatic cycle(input logic [31:0] f, input logic en, input logic [31:0] up,
                         input logic [31:0] ut, input logic tk, input logic fl);
        logic        mt;
        logic [31:0] mn;
        @(negedge clk);
        bus.fetch_pc      = f;
        bus.update_en     = en;
        bus.update_pc     = up;
        bus.update_target = ut;
        bus.update_taken  = tk;
        bus.flush         = fl;
        #1;
        obs_taken = bus.predict_taken;
        obs_pc    = bus.predict_next_pc;
        model_predict(f, mt, mn);
        check("model_taken", {31'd0, obs_taken}, {31'd0, mt});
        check("model_next_pc", obs_pc, mn);
        model_update(en, up, ut, tk, fl);
    endtask

    task automatic fetch(input logic [31:0] f);
        cycle(f, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        cycle(32'h0, 1'b1, pc, tgt, tk, 1'b0);
    endtask

    task automatic expect_pred(input string tag, input logic t, input logic [31:0] n);
        check({tag, "_taken"}, {31'd0, obs_taken}, {31'd0, t});
        check({tag, "_next_pc"}, obs_pc, n);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.fetch_pc      = 32'h100;
        bus.update_en     = 1'b0;
        bus.update_pc     = 32'h0;
        bus.update_target = 32'h0;
        bus.update_taken  = 1'b0;
        bus.flush         = 1'b0;
        model_reset();
        #1;
        obs_taken = bus.predict_taken;
        obs_pc    = bus.predict_next_pc;
        expect_pred("in_reset", 1'b0, 32'h104);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fetch(32'h100);                     expect_pred("post_reset", 1'b0, 32'h104);

        // Allocate and hit.
        upd(32'h100, 32'h80, 1'b1);
        fetch(32'h100);                     expect_pred("alloc_hit", 1'b1, 32'h80);
        fetch(32'h104);                     expect_pred("neighbour_miss", 1'b0, 32'h108);

        // Counter hysteresis.
        repeat (4) upd(32'h100, 32'h80, 1'b1);
        fetch(32'h100);                     expect_pred("sat_taken", 1'b1, 32'h80);
        upd(32'h100, 32'h0, 1'b0);
        fetch(32'h100);                     expect_pred("one_nt", 1'b1, 32'h80);
        upd(32'h100, 32'h0, 1'b0);
        fetch(32'h100);                     expect_pred("two_nt", 1'b0, 32'h104);
        repeat (2) upd(32'h100, 32'h0, 1'b0);
        upd(32'h100, 32'h80, 1'b1);
        fetch(32'h100);                     expect_pred("from_zero", 1'b0, 32'h104);

        // Aliasing on index 0.
        fetch(32'h140);                     expect_pred("alias_miss", 1'b0, 32'h144);
        upd(32'h140, 32'h200, 1'b1);
        fetch(32'h140);                     expect_pred("alias_hit", 1'b1, 32'h200);
        fetch(32'h100);                     expect_pred("evicted", 1'b0, 32'h104);
        upd(32'h100, 32'h999, 1'b0);
        fetch(32'h140);                     expect_pred("nt_miss_noop", 1'b1, 32'h200);

        // Same-cycle lookup/update: old contents visible, new ones next cycle.
        upd(32'h100, 32'h80, 1'b1);
        cycle(32'h100, 1'b1, 32'h100, 32'h300, 1'b1, 1'b0);
        expect_pred("same_cycle_old", 1'b1, 32'h80);
        fetch(32'h100);                     expect_pred("same_cycle_new", 1'b1, 32'h300);

        // Flush beats a simultaneous update.
        upd(32'h104, 32'h500, 1'b1);
        cycle(32'h104, 1'b1, 32'h108, 32'h600, 1'b1, 1'b1);
        expect_pred("pre_flush", 1'b1, 32'h500);
        fetch(32'h100);                     expect_pred("flush_100", 1'b0, 32'h104);
        fetch(32'h104);                     expect_pred("flush_104", 1'b0, 32'h108);
        fetch(32'h108);                     expect_pred("flush_drop", 1'b0, 32'h10C);

        fetch(32'hFFFF_FFFC);               expect_pred("wrap", 1'b0, 32'h0);

        // Asynchronous reset between edges.
        upd(32'h100, 32'h80, 1'b1);
        fetch(32'h100);                     expect_pred("pre_async", 1'b1, 32'h80);
        #1 rst_n = 1'b0;
        #1;
        obs_taken = bus.predict_taken;
        obs_pc    = bus.predict_next_pc;
        expect_pred("async_rst", 1'b0, 32'h104);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h100);                     expect_pred("after_async", 1'b0, 32'h104);

        // Randomised traffic on a small PC pool so hits, aliases and saturation all occur.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] f, up;
            f  = (32'h100 + 32'h40 * $urandom_range(0, 3) + 32'h4 * $urandom_range(0, 2))
                 | 32'($urandom_range(0, 3));
            up = 32'h100 + 32'h40 * $urandom_range(0, 3) + 32'h4 * $urandom_range(0, 2);
            cycle(f, 1'($urandom_range(0, 1)), up, $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
